// File: rtl/debug_host_agent_pkg.sv
// Opcodes and default widths shared by the debug-unit UART host agent and its word assembler.
package debug_host_agent_pkg;

  typedef enum logic [1:0] {
    OP_NONE      = 2'd0,
    OP_LOAD_INST = 2'd1,
    OP_RUN       = 2'd2,
    OP_RUN_STEP  = 2'd3
  } dbg_op_e;

  localparam int DEF_UART_BITS = 8;
  localparam int DEF_PROC_BITS = 32;

endpackage

// File: rtl/debug_host_agent_assembler.sv
// Shifts rx bytes in LSB first and emits PROC_BITS words with their frame index.
// Word strobe is registered (one cycle after the final byte); no backpressure, bytes are never stalled.
module debug_word_assembler
  import debug_host_agent_pkg::*;
#(
  parameter int UART_BITS  = DEF_UART_BITS,
  parameter int PROC_BITS  = DEF_PROC_BITS,
  parameter int RESP_WORDS = 64,
  localparam int IDX_W     = (RESP_WORDS > 1) ? $clog2(RESP_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_byte_vld,
  input  logic [UART_BITS-1:0] i_byte,
  output logic                 o_word_valid,
  output logic [PROC_BITS-1:0] o_word_data,
  output logic [IDX_W-1:0]     o_word_index,
  output logic                 o_frame_done,
  output logic                 o_frame_end
);

  localparam int WORD_BYTES = PROC_BITS / UART_BITS;
  localparam int BC_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [PROC_BITS-1:0] shift_q, shift_d, shifted;
  logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic                 word_valid_q, word_valid_d;
  logic [PROC_BITS-1:0] word_data_q, word_data_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic                 frame_done_q, frame_done_d;
  logic                 word_last, frame_last;

  assign word_last   = (byte_cnt_q == BC_W'(WORD_BYTES - 1));
  assign frame_last  = (word_idx_q == IDX_W'(RESP_WORDS - 1));
  assign o_frame_end = i_byte_vld && word_last && frame_last && !i_clear;

  always_comb begin
    shifted                             = shift_q >> UART_BITS;
    shifted[PROC_BITS-1 -: UART_BITS]   = i_byte;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    word_data_d  = word_data_q;
    index_d      = index_q;
    word_valid_d = 1'b0;
    frame_done_d = 1'b0;
    if (i_clear) begin
      shift_d    = '0;
      byte_cnt_d = '0;
      word_idx_d = '0;
    end else if (i_byte_vld) begin
      if (word_last) begin
        shift_d      = '0;
        byte_cnt_d   = '0;
        word_valid_d = 1'b1;
        word_data_d  = shifted;
        index_d      = word_idx_q;
        frame_done_d = frame_last;
        word_idx_d   = frame_last ? '0 : word_idx_q + 1'b1;
      end else begin
        shift_d    = shifted;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      index_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      index_q      <= index_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_word_valid = word_valid_q;
  assign o_word_data  = word_data_q;
  assign o_word_index = index_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: rtl/debug_host_agent.sv
// Host-side debug UART initiator: sends opcode/LOAD bytes, reassembles RUN/STEP dumps. Outputs registered (1 cycle).
// Paced by i_tx_done per byte; commands only in IDLE. DEBUG_HOST_TIMEOUT_EN adds an rx/tx inactivity timeout.
module debug_host_agent
  import debug_host_agent_pkg::*;
#(
  parameter int UART_BITS        = DEF_UART_BITS,
  parameter int INSTRUCTION_BITS = 32,
  parameter int PROC_BITS        = DEF_PROC_BITS,
  parameter int RESP_WORDS       = 64,
  parameter int TIMEOUT_CYCLES   = 2**20,
  localparam int IDX_W           = (RESP_WORDS > 1) ? $clog2(RESP_WORDS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cmd_valid,
  input  logic [1:0]                  i_cmd_op,
  output logic                        o_cmd_ready,
  input  logic                        i_inst_valid,
  input  logic [INSTRUCTION_BITS-1:0] i_inst_data,
  input  logic                        i_inst_last,
  output logic                        o_inst_ready,
  output logic                        o_tx_start,
  output logic [UART_BITS-1:0]        o_tx_data,
  input  logic                        i_tx_done,
  input  logic [UART_BITS-1:0]        i_rx_data,
  input  logic                        i_rx_done,
  output logic                        o_word_valid,
  output logic [PROC_BITS-1:0]        o_word_data,
  output logic [IDX_W-1:0]            o_word_index,
  output logic                        o_frame_done,
  output logic                        o_busy,
  output logic                        o_error
);

  localparam int INST_BYTES = INSTRUCTION_BITS / UART_BITS;
  localparam int BCNT_W     = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;

  if (TIMEOUT_CYCLES < 2 || (INSTRUCTION_BITS % UART_BITS) != 0 ||
      (PROC_BITS % UART_BITS) != 0 || RESP_WORDS < 1) begin : g_bad_cfg
    $error("debug_host_agent: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_OP, S_LOAD_FETCH, S_LOAD_TX, S_LOAD_WAIT, S_RESP_RECV
  } state_e;

  state_e                      state_q, state_d;
  dbg_op_e                     op_q, op_d;
  logic [INSTRUCTION_BITS-1:0] inst_q, inst_d;
  logic                        last_q, last_d;
  logic [BCNT_W-1:0]           tx_cnt_q, tx_cnt_d;
  logic [UART_BITS-1:0]        tx_data_q, tx_data_d;
  logic                        tx_start_q, tx_start_d;
  logic                        inst_ready_q, inst_ready_d;
  logic                        load_done_q, load_done_d;
  logic                        error_q, error_d;
  logic                        busy_q, busy_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        timeout, asm_clear, asm_en, asm_frame_end, asm_frame_done;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    inst_d       = inst_q;
    last_d       = last_q;
    tx_cnt_d     = tx_cnt_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    inst_ready_d = 1'b0;
    load_done_d  = 1'b0;
    error_d      = 1'b0;
    asm_clear    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          if (i_cmd_op == OP_NONE) begin
            error_d = 1'b1;
          end else begin
            op_d           = dbg_op_e'(i_cmd_op);
            tx_data_d      = '0;
            tx_data_d[1:0] = i_cmd_op;
            tx_start_d     = 1'b1;
            asm_clear      = 1'b1;
            state_d        = S_WAIT_OP;
          end
        end
      end
      S_WAIT_OP: begin
        if (i_tx_done) state_d = (op_q == OP_LOAD_INST) ? S_LOAD_FETCH : S_RESP_RECV;
      end
      S_LOAD_FETCH: begin
        if (i_inst_valid) begin
          inst_d       = i_inst_data;
          last_d       = i_inst_last;
          inst_ready_d = 1'b1;
          tx_cnt_d     = '0;
          state_d      = S_LOAD_TX;
        end
      end
      S_LOAD_TX: begin
        tx_data_d  = inst_q[UART_BITS-1:0];
        inst_d     = inst_q >> UART_BITS;
        tx_start_d = 1'b1;
        state_d    = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        // inst_q already holds the next byte in its low lane, so back-to-back bytes need no gap.
        if (i_tx_done) begin
          if (tx_cnt_q == BCNT_W'(INST_BYTES - 1)) begin
            tx_cnt_d    = '0;
            load_done_d = last_q;
            state_d     = last_q ? S_IDLE : S_LOAD_FETCH;
          end else begin
            tx_cnt_d   = tx_cnt_q + 1'b1;
            tx_data_d  = inst_q[UART_BITS-1:0];
            inst_d     = inst_q >> UART_BITS;
            tx_start_d = 1'b1;
          end
        end
      end
      S_RESP_RECV: begin
        if (asm_frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      error_d   = 1'b1;
      asm_clear = 1'b1;
      state_d   = S_IDLE;
    end
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NONE;
      inst_q       <= '0;
      last_q       <= 1'b0;
      tx_cnt_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      inst_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      inst_q       <= inst_d;
      last_q       <= last_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      inst_ready_q <= inst_ready_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_active;

  assign to_active = (state_q inside {S_WAIT_OP, S_LOAD_WAIT, S_RESP_RECV}) && !i_rx_done && !i_tx_done;
  assign timeout   = to_active && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (to_active && !timeout) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign asm_en = i_rx_done && (state_q == S_RESP_RECV);

  debug_word_assembler #(
    .UART_BITS  (UART_BITS),
    .PROC_BITS  (PROC_BITS),
    .RESP_WORDS (RESP_WORDS)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (asm_clear),
    .i_byte_vld   (asm_en),
    .i_byte       (i_rx_data),
    .o_word_valid (o_word_valid),
    .o_word_data  (o_word_data),
    .o_word_index (o_word_index),
    .o_frame_done (asm_frame_done),
    .o_frame_end  (asm_frame_end)
  );

  assign o_cmd_ready  = cmd_ready_q;
  assign o_inst_ready = inst_ready_q;
  assign o_tx_start   = tx_start_q;
  assign o_tx_data    = tx_data_q;
  assign o_frame_done = load_done_q | asm_frame_done;
  assign o_busy       = busy_q;
  assign o_error      = error_q;

endmodule
